blake_round_ctrl: RTL
=====================

# blake_round_ctrl

Sequencing controller for the Blake-512 compression core. It accepts one message block per start handshake and tracks the 128-bit bit counter t across the blocks of a message. It steps the core through init, 16 rounds × 8 G-function steps and finalization, and drives the existing `blake_counter` as its step timer. It sits between the message-padding front end and the compression datapath.

## Interface
- No parameters; fixed Blake-512: 16 rounds, 8 G steps per round, 1024-bit blocks.
- clk  in  1  clock
- rstb  in  1  asynchronous active-low reset
- start  in  1  block request; accepted only while ready=1
- first_blk  in  1  sampled with start; 1 = first block of a new message
- blk_bits  in  11  message bits in this block, 0..1024; 0 = padding-only block
- ready  out  1  idle, start will be accepted
- busy  out  1  INIT, ROUND or FINAL active
- init_load  out  1  load v from h, salt and t_o
- round_ing  out  1  G-function step active; also drives the counter enable
- round_idx  out  4  current round 0..15
- g_idx  out  3  G step 0..7; 0-3 column, 4-7 diagonal
- diag  out  1  g_idx[2]
- final_en  out  1  fold v into h
- done  out  1  single-cycle pulse, block hash valid in h
- t_o  out  128  counter value used for this block

## Operation
- States: IDLE, INIT, ROUND, FINAL, DONE.
- IDLE
  - ready=1.
  - start=1 moves to INIT and captures first_blk and blk_bits.
- INIT
  - One cycle; init_load=1; next state ROUND.
- ROUND
  - round_ing=1; counter_idx runs 0..127.
  - round_idx = counter_idx[6:3]; g_idx = counter_idx[2:0].
  - count_done=1 (idx 127) moves to FINAL.
- FINAL
  - One cycle; final_en=1; next state DONE.
- DONE
  - One cycle; done=1; next state IDLE.
- Outputs are registered from the state. round_idx/g_idx are 0 outside ROUND.
- t arithmetic:
  - Internal accumulator t_acc is 128 bits.
  - On start acceptance: t_acc ← (first_blk ? 0 : t_acc) + blk_bits, modulo 2^128 with silent wrap.
  - t_o ← (blk_bits==0) ? 0 : new t_acc.
  - t_acc still holds the running count when blk_bits==0.
- t_o is stable from INIT through DONE and holds until the next accepted start.
- start while not ready is ignored, not queued. first_blk and blk_bits are don't-care when not accepted.
- blk_bits > 1024 is illegal. It is clamped to 1024 and sets a sticky assertion-only flag, not a port.
- Reset (rstb=0) at any time, including mid-ROUND:
  - State → IDLE immediately; all strobes 0.
  - t_acc, t_o = 0; counter returns to 0.
  - ready=1 after the first clk edge following deassertion.

## Timing
- start accepted at edge 0:
  - INIT in cycle 1.
  - ROUND in cycles 2..129 (128 steps).
  - FINAL in cycle 130.
  - done in cycle 131.
  - ready in cycle 132.
- Block-to-block throughput is 132 cycles; start held high is accepted again in cycle 132.
- round_ing is high for exactly 128 consecutive cycles per block.
- Counter index equals the step number in the same cycle.
- Reset values of all outputs:
  - ready=1.
  - busy, init_load, round_ing, final_en, done, diag = 0.
  - round_idx=0, g_idx=0, t_o=0.

## Structure
- Shared package `blake_pkg` holds:
  - state enum (IDLE/INIT/ROUND/FINAL/DONE);
  - BLAKE_ROUNDS=16, BLAKE_GSTEPS=8, BLAKE_BLKBITS=1024, T_W=128.
- Instantiates the existing `blake_counter` (round_ing → enable; counter_idx, count_done back). No other sub-module.
- t accumulator and FSM live in the top module.

## Test plan
- Single block: first_blk=1, blk_bits=1024, start.
  - init_load in cycle 1; round_ing cycles 2-129; final_en in 130; done in 131.
  - t_o=1024.
- Round/step mapping: at ROUND step 35, round_idx=4, g_idx=3, diag=0; at step 127, round_idx=15, g_idx=7, diag=1.
- Multi-block message: blk_bits 1024, 1024, 7 (first_blk only on the first) → t_o = 1024, 2048, 2055.
- Padding-only block: blocks 1024, then 0 → t_o = 1024 then 0; a following block with blk_bits=5, first_blk=0 gives t_o=1029.
- Wrap and ignore:
  - t_acc preloaded near 2^128−1, +1024 → wraps modulo 2^128.
  - start pulsed during ROUND → ignored; only one done.
- Reset mid-operation: rstb low at step 60 → all outputs at reset values at once; the next block runs the full 132 cycles with t_o computed from t_acc=0.

Source files
------------

// File: rtl/blake_pkg.sv
// Shared types and constants for the Blake-512 compression sequencing logic.
package blake_pkg;

  localparam int BLAKE_ROUNDS  = 16;
  localparam int BLAKE_GSTEPS  = 8;
  localparam int BLAKE_BLKBITS = 1024;
  localparam int T_W           = 128;

  // One counter index per G step across all rounds.
  localparam int BLAKE_STEPS   = BLAKE_ROUNDS * BLAKE_GSTEPS;
  localparam int IDX_W         = $clog2(BLAKE_STEPS);
  localparam int BITS_W        = $clog2(BLAKE_BLKBITS) + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } blake_state_e;

endpackage

// File: rtl/blake_counter.sv
// G-step timer: counts 0..BLAKE_STEPS-1 while enabled and wraps back to 0.
module blake_counter
  import blake_pkg::*;
(
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  output logic [IDX_W-1:0] counter_idx,
  output logic             count_done
);

  logic [IDX_W-1:0] cnt_q;
  logic [IDX_W-1:0] cnt_d;

  // Advance one step per enabled cycle; natural wrap returns to 0 after the last step.
  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign counter_idx = cnt_q;
  assign count_done  = (cnt_q == IDX_W'(BLAKE_STEPS - 1));

endmodule

// File: rtl/blake_round_ctrl.sv
// Blake-512 block sequencer: accepts a block, tracks the message bit counter t,
// and walks the core through init, 16 rounds x 8 G steps and finalization.
//
// state | meaning
// IDLE  | waiting for start; ready=1
// INIT  | load v from h, salt, t_o (one cycle)
// ROUND | one G step per cycle, 128 steps timed by blake_counter
// FINAL | fold v into h (one cycle)
// DONE  | block hash valid, one-cycle done pulse
module blake_round_ctrl
  import blake_pkg::*;
(
  input  logic              clk,
  input  logic              rstb,
  input  logic              start,
  input  logic              first_blk,
  input  logic [BITS_W-1:0] blk_bits,
  output logic              ready,
  output logic              busy,
  output logic              init_load,
  output logic              round_ing,
  output logic [3:0]        round_idx,
  output logic [2:0]        g_idx,
  output logic              diag,
  output logic              final_en,
  output logic              done,
  output logic [T_W-1:0]    t_o
);

  blake_state_e      state_q, state_d;
  logic              accept;
  logic [T_W-1:0]    t_acc_q, t_acc_d;
  logic [T_W-1:0]    t_o_q, t_o_d;
  logic              bits_ovf_q, bits_ovf_d;
  logic [BITS_W-1:0] bits_c;
  logic [IDX_W-1:0]  counter_idx;
  logic              count_done;

  blake_counter u_counter (
    .clk         (clk),
    .rstb        (rstb),
    .en          (round_ing),
    .counter_idx (counter_idx),
    .count_done  (count_done)
  );

  // Next-state decode; start is only honoured from IDLE, never queued.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_INIT;
          accept  = 1'b1;
        end
      end
      ST_INIT:  state_d = ST_ROUND;
      ST_ROUND: if (count_done) state_d = ST_FINAL;
      ST_FINAL: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Bit-counter update on acceptance; a padding-only block reports t=0 but keeps the running total.
  always_comb begin
    t_acc_d    = t_acc_q;
    t_o_d      = t_o_q;
    bits_ovf_d = bits_ovf_q;
    bits_c     = (blk_bits > BITS_W'(BLAKE_BLKBITS)) ? BITS_W'(BLAKE_BLKBITS) : blk_bits;
    if (accept) begin
      t_acc_d = (first_blk ? '0 : t_acc_q) + T_W'(bits_c);
      t_o_d   = (bits_c == '0) ? '0 : t_acc_d;
      if (blk_bits > BITS_W'(BLAKE_BLKBITS)) bits_ovf_d = 1'b1;
    end
  end

  // State, accumulator and sticky illegal-length flag registers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= ST_IDLE;
      t_acc_q    <= '0;
      t_o_q      <= '0;
      bits_ovf_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      t_acc_q    <= t_acc_d;
      t_o_q      <= t_o_d;
      bits_ovf_q <= bits_ovf_d;
    end
  end

  // An oversize block length is an upstream bug; the clamp keeps hardware sane meanwhile.
  assert property (@(posedge clk) disable iff (!rstb) !bits_ovf_q)
    else $error("blake_round_ctrl: blk_bits above block size was accepted");

  assign ready     = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_INIT) || (state_q == ST_ROUND) || (state_q == ST_FINAL);
  assign init_load = (state_q == ST_INIT);
  assign round_ing = (state_q == ST_ROUND);
  assign final_en  = (state_q == ST_FINAL);
  assign done      = (state_q == ST_DONE);
  assign round_idx = round_ing ? counter_idx[6:3] : 4'd0;
  assign g_idx     = round_ing ? counter_idx[2:0] : 3'd0;
  assign diag      = g_idx[2];
  assign t_o       = t_o_q;

endmodule
